// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encrypt datapath, one full round per clock.
// Accepts a plaintext block over valid/ready and runs Nr rounds against the
// packed round-key bus supplied by KeyExpansion. It holds the ciphertext until
// the consumer completes the output handshake. The key bus is not latched, so
// the upstream logic must hold round_keys steady while a block is in flight.
module aes_round_engine #(
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [128*(Nr+1)-1:0]   round_keys,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [32*Nb-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*Nb-1:0]        out_data,
  output logic                    busy
);

  localparam int BW = 32 * Nb;
  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] LAST_RND = RW'(Nr);
  localparam logic [RW-1:0] FIRST_RND = RW'(1);

  // Forward S-box, entry 0 in the most significant byte, 16 entries per row
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [RW-1:0] rnd;
  logic [BW-1:0] block;
  logic [BW-1:0] key_arr [Nr+1];
  logic [BW-1:0] cur_key;
  logic [BW-1:0] sb_out;
  logic [BW-1:0] sr_out;
  logic [BW-1:0] mc_out;
  logic [BW-1:0] round_out;
  logic          last_round;

  // S-box lookup; entry x sits (255-x) bytes up from the table LSB
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes: independent S-box substitution of all 16 bytes
  function automatic logic [BW-1:0] sub_bytes(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[BW-1-8*i -: 8] = sbox(s[BW-1-8*i -: 8]);
    end
    return r;
  endfunction

  // ShiftRows: byte i is row i%4, column i/4; row r rotates left by r columns
  function automatic logic [BW-1:0] shift_rows(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[BW-1-8*(row+4*c) -: 8] = s[BW-1-8*(row+4*(((c+row)%4))) -: 8];
      end
    end
    return r;
  endfunction

  // MixColumns: each column multiplied by the fixed {02,03,01,01} circulant
  function automatic logic [BW-1:0] mix_columns(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BW-1-8*(4*c)   -: 8];
      a1 = s[BW-1-8*(4*c+1) -: 8];
      a2 = s[BW-1-8*(4*c+2) -: 8];
      a3 = s[BW-1-8*(4*c+3) -: 8];
      r[BW-1-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[BW-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[BW-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[BW-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Unpack the round-key bus so the current key can be selected by round number
  always_comb begin
    for (int k = 0; k <= Nr; k++) begin
      key_arr[k] = round_keys[128*k +: 128];
    end
  end

  assign cur_key    = key_arr[rnd];
  assign last_round = (rnd == LAST_RND);
  assign sb_out     = sub_bytes(block);
  assign sr_out     = shift_rows(sb_out);
  assign mc_out     = mix_columns(sr_out);
  assign round_out  = (last_round ? sr_out : mc_out) ^ cur_key;

  // State register; reset discards any block in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, all derived from the current state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (last_round) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: initial AddRoundKey on accept, one round per clock, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      block    <= '0;
      rnd      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            block <= in_data ^ key_arr[0];
            rnd   <= FIRST_RND;
          end
        end
        ROUND: begin
          block <= round_out;
          if (last_round) begin
            out_data <= round_out;
          end else begin
            rnd <= rnd + FIRST_RND;
          end
        end
        DONE: begin
          if (out_ready) begin
            rnd <= '0;
          end
        end
        default: begin
          rnd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: table-driven and sequence checks of aes_round_engine
// against known-answer vectors and a GF(2^8)-arithmetic AES-128 model.
module tb_aes_round_engine;

  localparam int NR = 10;
  localparam int KW = 128 * (NR + 1);

  logic          clk;
  logic          rst;
  logic [KW-1:0] round_keys;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;

  int vectors;
  int miscompares;

  logic [7:0] sbox_m [256];

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_engine #(.Nb(4), .Nr(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .round_keys (round_keys),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [KW-1:0] bus;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    bus = '0;
    for (int r = 0; r <= NR; r++) bus[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return bus;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [KW-1:0] rk;
    logic [127:0]  kr;
    logic [7:0]    st [16];
    logic [7:0]    tmp [16];
    logic [127:0]  res;
    rk = expand_key(key);
    kr = rk[127:0];
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ kr[127-8*i -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_m[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[row + 4*c] = st[row + 4*((c + row) % 4)];
      for (int i = 0; i < 16; i++) st[i] = tmp[i];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          tmp[4*c]   = gmul(8'h02, st[4*c]) ^ gmul(8'h03, st[4*c+1]) ^ st[4*c+2] ^ st[4*c+3];
          tmp[4*c+1] = st[4*c] ^ gmul(8'h02, st[4*c+1]) ^ gmul(8'h03, st[4*c+2]) ^ st[4*c+3];
          tmp[4*c+2] = st[4*c] ^ st[4*c+1] ^ gmul(8'h02, st[4*c+2]) ^ gmul(8'h03, st[4*c+3]);
          tmp[4*c+3] = gmul(8'h03, st[4*c]) ^ st[4*c+1] ^ st[4*c+2] ^ gmul(8'h02, st[4*c+3]);
        end
        for (int i = 0; i < 16; i++) st[i] = tmp[i];
      end
      kr = rk[128*r +: 128];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ kr[127-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Offer one block, then wait for out_valid; optionally pulse in_valid mid-run
  task automatic applyStimulus(input logic [127:0] pt, input int pulse_at,
                               input logic [127:0] pulse_pt, output int lat);
    in_data  = pt;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == pulse_at) begin
        in_valid = 1'b1;
        in_data  = pulse_pt;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("out_valid_reached", {127'd0, out_valid}, 128'd1);
  endtask

  task automatic finishHandshake(input logic [127:0] ct);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("post_hs_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("post_hs_busy", {127'd0, busy}, 128'd0);
    checkOutput("post_hs_out_data_held", out_data, ct);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int cyc;
    int nacc;
    int nout;
    int acc_cyc [2];
    logic [127:0] outs [2];
    logic acc_pre;
    logic hs_pre;
    logic switched;
    logic [127:0] data_pre;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    round_keys  = '0;

    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

    vecs[0] = '{name: "fips_b",  key: K1, pt: P1, ct: C1};
    vecs[1] = '{name: "fips_c1", key: K2, pt: P2, ct: C2};
    for (int i = 2; i < 8; i++) begin
      vecs[i].name = $sformatf("rand%0d", i);
      vecs[i].key  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct   = model_encrypt(vecs[i].key, vecs[i].pt);
    end

    // Reset state
    tick();
    tick();
    checkOutput("reset_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("reset_busy", {127'd0, busy}, 128'd0);
    checkOutput("reset_out_data", out_data, 128'd0);
    rst = 1'b0;
    tick();

    // Table-driven known-answer and random vectors
    for (int v = 0; v < 8; v++) begin
      round_keys = expand_key(vecs[v].key);
      applyStimulus(vecs[v].pt, -1, '0, lat);
      checkOutput({vecs[v].name, "_ct"}, out_data, vecs[v].ct);
      checkOutput({vecs[v].name, "_latency"}, 128'(lat), 128'(NR));
      finishHandshake(vecs[v].ct);
      tick();
    end

    // Backpressure: hold out_ready low for 5 clocks
    round_keys = expand_key(K1);
    applyStimulus(P1, -1, '0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_out_valid", {127'd0, out_valid}, 128'd1);
      checkOutput("bp_out_data", out_data, C1);
      checkOutput("bp_in_ready", {127'd0, in_ready}, 128'd0);
      checkOutput("bp_busy", {127'd0, busy}, 128'd1);
    end
    finishHandshake(C1);
    tick();

    // Back-to-back with in_valid held high and out_ready high
    round_keys = expand_key(K1);
    in_data    = P1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    cyc = 0; nacc = 0; nout = 0; switched = 1'b0;
    while (nout < 2 && cyc < 60) begin
      acc_pre  = in_valid && in_ready;
      hs_pre   = out_valid && out_ready;
      data_pre = out_data;
      tick();
      cyc++;
      if (acc_pre && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (hs_pre) begin
        outs[nout] = data_pre;
        nout++;
      end
      if (out_valid && !switched) begin
        round_keys = expand_key(K2);
        in_data    = P2;
        switched   = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_outputs_seen", 128'(nout), 128'd2);
    checkOutput("b2b_accepts_seen", 128'(nacc), 128'd2);
    if (nout == 2) begin
      checkOutput("b2b_ct1", outs[0], C1);
      checkOutput("b2b_ct2", outs[1], C2);
    end
    if (nacc == 2) checkOutput("b2b_accept_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    tick();

    // Reset asserted mid-encryption at round 5
    round_keys = expand_key(K1);
    in_data    = P1;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("midrst_out_data", out_data, 128'd0);
    checkOutput("midrst_busy", {127'd0, busy}, 128'd0);
    checkOutput("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    applyStimulus(P1, -1, '0, lat);
    checkOutput("midrst_next_ct", out_data, C1);
    checkOutput("midrst_next_latency", 128'(lat), 128'(NR));
    finishHandshake(C1);
    tick();

    // in_valid pulsed with a different plaintext while rounds are running
    applyStimulus(P1, 3, P2, lat);
    checkOutput("ignored_pulse_ct", out_data, C1);
    checkOutput("ignored_pulse_latency", 128'(lat), 128'(NR));
    finishHandshake(C1);
    tick();
    checkOutput("ignored_pulse_no_capture", {127'd0, busy}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
